// File: rtl/efuse_pkg.sv
// -----------------------------------------------------------------------------
// efuse_pkg
// Shared types and constants for the eFuse macro emulator and its checker.
//   emu_state_e  : responder state (IDLE / RD / PG)
//   EFUSE_BITS   : fuse word width
//   EFUSE_PTR_W  : bit pointer width (one extra bit so it can reach 32)
//   READ_WIN     : driver read window in clk cycles
//   PROG_WIN     : driver program window in clk cycles
// -----------------------------------------------------------------------------
package efuse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    PG   = 2'd2
  } emu_state_e;

  localparam int EFUSE_BITS  = 32;
  localparam int EFUSE_PTR_W = 6;

  localparam int READ_WIN = 32;
  localparam int PROG_WIN = 256;

endpackage

// File: rtl/efuse_macro_emu_if.sv
// -----------------------------------------------------------------------------
// efuse_macro_emu_if
// SISO eFuse pin bundle between the eFuse driver (master) and the macro or
// its emulator (slave).
//   EFUSE_CS   : chip select, a frame lasts while it is high
//   EFUSE_PGM  : program pulse, burns the current bit in a program frame
//   EFUSE_SCLK : serial bit clock, the bit pointer advances on its fall
//   EFUSE_RW   : 1 = program frame, 0 = read frame; sampled on CS rise
//   EFUSE_DOUT : serial read data, LSB first
// Handshake: there is no valid/ready pair. The master owns all timing: RW is
// stable before CS rises and while CS is high, one bit per SCLK period, and
// the slave presents bit n on DOUT from two clk cycles after the (n-1)th SCLK
// fall until the nth SCLK fall.
// -----------------------------------------------------------------------------
interface efuse_macro_emu_if;
  logic EFUSE_CS;
  logic EFUSE_PGM;
  logic EFUSE_SCLK;
  logic EFUSE_RW;
  logic EFUSE_DOUT;

  modport master (
    output EFUSE_CS,
    output EFUSE_PGM,
    output EFUSE_SCLK,
    output EFUSE_RW,
    input  EFUSE_DOUT
  );

  modport slave (
    input  EFUSE_CS,
    input  EFUSE_PGM,
    input  EFUSE_SCLK,
    input  EFUSE_RW,
    output EFUSE_DOUT
  );
endinterface

// File: rtl/efuse_emu_chk.sv
// -----------------------------------------------------------------------------
// efuse_emu_chk
// Protocol checker for the eFuse emulator. Only instantiated when
// EFUSE_EMU_CHECK_EN is defined.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cs, cs_d     : raw chip select and its registered copy
//   pgm, rw      : raw program pulse and read/write select
//   in_rd        : responder is in a read frame
//   bit_step     : an SCLK fall that advances the pointer this cycle
//   ptr_at_end   : pointer already at 32 (all bits consumed)
//   proto_err    : sticky violation flag, cleared only by reset
// -----------------------------------------------------------------------------
module efuse_emu_chk #(
  parameter int PGM_MIN_CYC = 1,
  parameter int PGM_MAX_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic cs_d,
  input  logic pgm,
  input  logic rw,
  input  logic in_rd,
  input  logic bit_step,
  input  logic ptr_at_end,
  output logic proto_err
);

  // The counter only needs to tell "above max" apart, so it saturates at
  // PGM_MAX_CYC + 1 instead of growing with the pulse.
  localparam int CNT_W = $clog2(PGM_MAX_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(PGM_MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(PGM_MIN_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PGM_MAX_CYC);

  logic             pgm_d;
  logic             rw_d;
  logic [CNT_W-1:0] pgm_cnt_q;
  logic             pgm_fall;
  logic             width_bad;
  logic             violation;
  logic             err_q;

  assign pgm_fall  = ~pgm & pgm_d;
  // On the fall cycle the counter holds the length of the run that just ended.
  assign width_bad = pgm_fall && ((pgm_cnt_q < CNT_MIN) || (pgm_cnt_q > CNT_MAX));

  // RW is only required to be stable once CS has been high for a full cycle,
  // so an RW change coincident with the CS edge itself is not flagged.
  assign violation = (pgm & ~cs)
                   | (pgm & in_rd)
                   | ((rw != rw_d) & cs & cs_d)
                   | (bit_step & ptr_at_end)
                   | width_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pgm_d     <= 1'b0;
      rw_d      <= 1'b0;
      pgm_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pgm_d <= pgm;
      rw_d  <= rw;
      if (!pgm) begin
        pgm_cnt_q <= '0;
      end else if (pgm_cnt_q != CNT_SAT) begin
        pgm_cnt_q <= pgm_cnt_q + 1'b1;
      end
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

  assign proto_err = err_q;

endmodule

// File: rtl/efuse_macro_emu.sv
// -----------------------------------------------------------------------------
// efuse_macro_emu
// Cycle-based, volatile emulation of the 32-bit SISO OTP eFuse macro. Sits
// behind the eFuse driver in the same clk domain. Burns set bits 0 -> 1 only,
// serialises the fuse word LSB first on reads.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   efuse      : eFuse pin bundle (slave side)
//   fuse_word  : current fuse contents (backdoor observe)
//   burn_cnt   : number of bits burned 0 -> 1 since reset
//   busy       : a frame is in progress (state != IDLE)
//   proto_err  : sticky protocol-violation flag
//   state_dbg  : current responder state
// Build option: define EFUSE_EMU_CHECK_EN to include the protocol checker;
// without it proto_err is tied low and read/program behaviour is unchanged.
// -----------------------------------------------------------------------------
module efuse_macro_emu
  import efuse_pkg::*;
#(
  parameter logic [31:0] INIT_VAL    = 32'h0,
  parameter int          PGM_MIN_CYC = 1,
  parameter int          PGM_MAX_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  efuse_macro_emu_if.slave       efuse,
  output logic [EFUSE_BITS-1:0]  fuse_word,
  output logic [EFUSE_PTR_W-1:0] burn_cnt,
  output logic                   busy,
  output logic                   proto_err,
  output emu_state_e             state_dbg
);

  if ((PGM_MIN_CYC < 1) || (PGM_MAX_CYC < PGM_MIN_CYC)) begin : g_bad_pgm_window
    $error("efuse_macro_emu: PGM_MIN_CYC/PGM_MAX_CYC window is empty");
  end

  logic cs, pgm, sclk, rw;
  assign cs   = efuse.EFUSE_CS;
  assign pgm  = efuse.EFUSE_PGM;
  assign sclk = efuse.EFUSE_SCLK;
  assign rw   = efuse.EFUSE_RW;

  logic cs_d, sclk_d;
  logic cs_rise, cs_fall, sclk_fall;

  emu_state_e             state_q, state_n;
  logic [EFUSE_PTR_W-1:0] ptr_q;
  logic                   pgm_pend_q, pgm_pend_n;
  logic [EFUSE_BITS-1:0]  fuse_q;
  logic [EFUSE_PTR_W-1:0] burn_cnt_q;
  logic                   dout_q;

  logic       in_frame;
  logic       frame_end;
  logic       bit_step;
  logic       ptr_in_range;
  logic [4:0] bit_idx;
  logic       burn;

  assign cs_rise   = cs & ~cs_d;
  assign cs_fall   = ~cs & cs_d;
  assign sclk_fall = ~sclk & sclk_d;

  assign in_frame     = (state_q != IDLE);
  assign frame_end    = in_frame & cs_fall;
  // A CS fall swallows an SCLK fall on the same cycle: no step, no burn.
  assign bit_step     = in_frame & sclk_fall & ~cs_fall;
  assign ptr_in_range = (ptr_q < EFUSE_PTR_W'(EFUSE_BITS));
  assign bit_idx      = ptr_q[4:0];
  assign burn         = (state_q == PG) & bit_step & pgm_pend_q & ptr_in_range;

  // Next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (cs_rise) state_n = rw ? PG : RD;
      RD, PG: if (cs_fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A pending PGM is consumed by the burn it causes; a PGM seen on the very
  // cycle of that burn re-arms for the next bit.
  always_comb begin
    pgm_pend_n = pgm_pend_q;
    if (frame_end) begin
      pgm_pend_n = 1'b0;
    end else begin
      if (burn) pgm_pend_n = 1'b0;
      if ((state_q == PG) && pgm) pgm_pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d       <= 1'b0;
      sclk_d     <= 1'b0;
      state_q    <= IDLE;
      ptr_q      <= '0;
      pgm_pend_q <= 1'b0;
      fuse_q     <= INIT_VAL;
      burn_cnt_q <= '0;
      dout_q     <= 1'b0;
    end else begin
      cs_d       <= cs;
      sclk_d     <= sclk;
      state_q    <= state_n;
      pgm_pend_q <= pgm_pend_n;

      if (cs_rise || frame_end) begin
        ptr_q <= '0;
      end else if (bit_step && ptr_in_range) begin
        ptr_q <= ptr_q + 1'b1;
      end

      if (burn) begin
        fuse_q[bit_idx] <= 1'b1;
        if (!fuse_q[bit_idx]) begin
          burn_cnt_q <= burn_cnt_q + 1'b1;
        end
      end

      // Re-evaluated every cycle so DOUT tracks the pointer with one clk lag.
      dout_q <= ((state_q == RD) && ptr_in_range) ? fuse_q[bit_idx] : 1'b0;
    end
  end

  assign efuse.EFUSE_DOUT = dout_q;
  assign fuse_word        = fuse_q;
  assign burn_cnt         = burn_cnt_q;
  assign busy             = in_frame;
  assign state_dbg        = state_q;

`ifdef EFUSE_EMU_CHECK_EN
  efuse_emu_chk #(
    .PGM_MIN_CYC (PGM_MIN_CYC),
    .PGM_MAX_CYC (PGM_MAX_CYC)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .cs_d       (cs_d),
    .pgm        (pgm),
    .rw         (rw),
    .in_rd      (state_q == RD),
    .bit_step   (bit_step),
    .ptr_at_end (ptr_q == EFUSE_PTR_W'(EFUSE_BITS)),
    .proto_err  (proto_err)
  );
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_macro_emu.sv
module tb_efuse_macro_emu;
  import efuse_pkg::*;

  localparam logic [31:0] INIT = 32'hA5A5_0F0F;
`ifdef EFUSE_EMU_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  efuse_macro_emu_if bus();

  logic [31:0] fuse_word;
  logic [5:0]  burn_cnt;
  logic        busy;
  logic        proto_err;
  emu_state_e  state_dbg;

  efuse_macro_emu #(
    .INIT_VAL    (INIT),
    .PGM_MIN_CYC (1),
    .PGM_MAX_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .efuse     (bus),
    .fuse_word (fuse_word),
    .burn_cnt  (burn_cnt),
    .busy      (busy),
    .proto_err (proto_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_fuse;
  int          model_burn;

  typedef struct {
    logic        is_prog;
    logic [31:0] din;
    logic [31:0] exp_word;
    logic [5:0]  exp_burn;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int popcount32(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_pins();
    bus.EFUSE_CS   = 1'b0;
    bus.EFUSE_PGM  = 1'b0;
    bus.EFUSE_SCLK = 1'b0;
    bus.EFUSE_RW   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_pins();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_fuse = INIT;
    model_burn = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fuse"},  fuse_word, INIT);
    check({tag, "_burn"},  32'(burn_cnt), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_err"},   32'(proto_err), 32'd0);
    check({tag, "_dout"},  32'(bus.EFUSE_DOUT), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // Read frame with npulses SCLK periods; DOUT sampled mid-high.
  task automatic read_word(input int npulses, output logic [31:0] data, output logic extra);
    data  = '0;
    extra = 1'b0;
    bus.EFUSE_RW = 1'b0;
    tick();
    bus.EFUSE_CS = 1'b1;
    tick(3);
    check("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < npulses; i++) begin
      bus.EFUSE_SCLK = 1'b1;
      tick(2);
      if (i < 32) data[i] = bus.EFUSE_DOUT;
      else        extra   = bus.EFUSE_DOUT;
      bus.EFUSE_SCLK = 1'b0;
      tick(3);
    end
    bus.EFUSE_CS = 1'b0;
    tick(2);
  endtask

  // Program frame; a PGM pulse of 'width' clk cycles in each window with
  // din[i] = 1. If abort_bit >= 0 the task returns mid-window of that bit
  // with CS and SCLK still high.
  task automatic prog_word(input logic [31:0] din, input int width, input int abort_bit);
    bus.EFUSE_RW = 1'b1;
    tick();
    bus.EFUSE_CS = 1'b1;
    tick(3);
    for (int i = 0; i < 32; i++) begin
      bus.EFUSE_SCLK = 1'b1;
      tick();
      if (i == 0) check("pg_dout_zero", 32'(bus.EFUSE_DOUT), 32'd0);
      if (din[i]) begin
        bus.EFUSE_PGM = 1'b1;
        tick(width);
        bus.EFUSE_PGM = 1'b0;
      end
      tick();
      if (i == abort_bit) return;
      bus.EFUSE_SCLK = 1'b0;
      tick(2);
    end
    bus.EFUSE_CS = 1'b0;
    tick(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #20ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd;
    logic        extra;
    logic [31:0] din;
    logic [31:0] exp_w;

    vecs[0] = '{1'b0, 32'h0,         32'hA5A5_0F0F, 6'd0};
    vecs[1] = '{1'b1, 32'h0000_8001, 32'hA5A5_8F0F, 6'd1};
    vecs[2] = '{1'b0, 32'h0,         32'hA5A5_8F0F, 6'd1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd16};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd16};
    vecs[5] = '{1'b0, 32'h0,         32'hFFFF_FFFF, 6'd16};

    idle_pins();
    rst_n = 1'b0;
    tick(2);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    tick(2);
    check_reset_vals("rst_rel");

    // Table-driven directed sequence
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_prog) begin
        prog_word(vecs[v].din, 2, -1);
      end else begin
        read_word(32, rd, extra);
        check($sformatf("tbl%0d_rd", v), rd, vecs[v].exp_word);
      end
      check($sformatf("tbl%0d_fuse", v), fuse_word, vecs[v].exp_word);
      check($sformatf("tbl%0d_burn", v), 32'(burn_cnt), 32'(vecs[v].exp_burn));
      check($sformatf("tbl%0d_err", v), 32'(proto_err), 32'd0);
    end

    // Over-long PGM pulse (6 cycles, max 4), then a legal read
    prog_word(32'h0000_0001, 6, -1);
    check("wide_pgm_err", 32'(proto_err), 32'(CHK));
    check("wide_pgm_burn", 32'(burn_cnt), 32'd16);
    read_word(32, rd, extra);
    check("wide_pgm_rd", rd, 32'hFFFF_FFFF);
    check("wide_pgm_err_sticky", 32'(proto_err), 32'(CHK));

    // Reset during a program frame at bit 10
    apply_reset();
    check_reset_vals("rst2");
    prog_word(32'hFFFF_FFFF, 2, 10);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_fuse", fuse_word, INIT | 32'h0000_03FF);
    check("mid_burn", 32'(burn_cnt), 32'(popcount32(~INIT & 32'h0000_03FF)));
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    idle_pins();
    tick();
    rst_n = 1'b1;
    tick(2);
    model_fuse = INIT;
    model_burn = 0;
    read_word(32, rd, extra);
    check("midrst_rd", rd, INIT);

    // 33 SCLK pulses in one read frame
    read_word(33, rd, extra);
    check("rd33_bits", rd, fuse_word);
    check("rd33_bits_init", rd, INIT);
    check("rd33_dout33", 32'(extra), 32'd0);
    check("rd33_err", 32'(proto_err), 32'(CHK));

    // Randomized read/program against the reference model
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        din = $urandom() & $urandom();
        model_burn += popcount32(din & ~model_fuse);
        model_fuse |= din;
        prog_word(din, $urandom_range(1, 4), -1);
        check($sformatf("rnd%0d_fuse", n), fuse_word, model_fuse);
        check($sformatf("rnd%0d_burn", n), 32'(burn_cnt), 32'(model_burn));
      end else begin
        exp_q.push_back(model_fuse);
        read_word(32, rd, extra);
        exp_w = exp_q.pop_front();
        check($sformatf("rnd%0d_rd", n), rd, exp_w);
      end
    end
    check("rnd_err", 32'(proto_err), 32'd0);
    check("rnd_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/efuse_macro_emu.md
Name: efuse_macro_emu

Overview:
- Synthesizable cycle-based model of the 32-bit SISO one-time-programmable eFuse macro; the responder side of the EFUSE_CS/PGM/SCLK/RW/DOUT interface.
- Used in FPGA prototypes and in simulation in place of the hard macro. Sits directly behind the eFuse driver, in the same 25 MHz osc clock domain.
- Stores 32 fuse bits and burns bits on PGM pulses; OTP semantics, so a burn can only set a bit from 0 to 1.
- Serialises the fuse word LSB-first on DOUT during reads, and flags protocol violations.

Parameters:
- INIT_VAL, 32'h0, fuse contents after reset (the emulator is volatile).
- PGM_MIN_CYC, 1, minimum legal PGM high width in clk cycles.
- PGM_MAX_CYC, 4, maximum legal PGM high width in clk cycles.

Ports:
- clk  in  1  25 MHz osc clock
- rst_n  in  1  asynchronous reset, active low; release is synchronous to clk
- EFUSE_CS  in  1  chip select
- EFUSE_PGM  in  1  program pulse
- EFUSE_SCLK  in  1  serial bit clock, sampled by clk
- EFUSE_RW  in  1  1 = program, 0 = read; sampled on CS rise
- EFUSE_DOUT  out  1  serial read data
- fuse_word  out  32  current fuse contents (backdoor observe)
- burn_cnt  out  6  number of bits burned 0→1 since reset
- busy  out  1  state != IDLE
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values:
  - fuse store = INIT_VAL; fuse_word = INIT_VAL.
  - EFUSE_DOUT = 0, burn_cnt = 0, busy = 0, proto_err = 0.
  - State = IDLE, ptr = 0.
- Input registration: CS, PGM, SCLK and RW are each registered once (the _d copies). Edges are detected as current value versus _d value.
  - sclk_rise = SCLK & ~sclk_d; sclk_fall = ~SCLK & sclk_d.
  - cs_rise and cs_fall are formed the same way.
- States: IDLE, RD, PG.
  - IDLE → RD on cs_rise with RW = 0.
  - IDLE → PG on cs_rise with RW = 1.
  - RD/PG → IDLE on cs_fall; ptr is cleared and pgm_pend is cleared.
  - cs_fall wins over any simultaneous sclk_fall: no burn and no ptr increment on that cycle.
- Bit pointer: ptr is 6 bits, cleared on cs_rise. It increments on each sclk_fall in RD or PG and saturates at 32.
- RD mode:
  - EFUSE_DOUT is registered: EFUSE_DOUT <= (ptr < 32) ? fuse[ptr] : 0, updated every cycle.
  - DOUT therefore settles within 2 clk of an SCLK fall and is held stable across the whole next SCLK high phase.
  - Bit 0 is valid before the first SCLK rise, so the driver samples mid-high.
  - EFUSE_DOUT = 0 in IDLE and PG.
- PG mode:
  - Any cycle with PGM = 1 sets pgm_pend.
  - On sclk_fall with pgm_pend = 1 and ptr < 32: fuse[ptr] <= 1 and pgm_pend clears.
  - burn_cnt increments only if that bit was previously 0. Re-burning a 1 is legal and a no-op.
  - A bit with no PGM pulse in its window stays unchanged.
  - PGM may precede the SCLK rise within the same window; this is legal.
- proto_err is sticky until reset. It sets on any of:
  - PGM = 1 while CS = 0;
  - PGM = 1 while in RD;
  - RW changing while CS = 1;
  - sclk_fall while ptr = 32 (33rd bit);
  - a PGM high run shorter than PGM_MIN_CYC or longer than PGM_MAX_CYC (checker only).
- Reset mid-operation: everything returns to reset values, including fuse = INIT_VAL, and partial burns are lost. This is intended: the emulator is volatile.
- fuse_word reflects a burn on the cycle after the sclk_fall that commits it.

Optional Feature:
- Macro: EFUSE_EMU_CHECK_EN.
- Defined: the PGM pulse-width checker is present (a counter on the PGM high run, evaluated at PGM fall), and all proto_err sources are active.
- Undefined: the width counter and all proto_err logic are removed; proto_err is tied to 0. Functional read/program behaviour is identical.

Decomposition:
- Shared package efuse_pkg holds:
  - state enum emu_state_e {IDLE, RD, PG};
  - localparams EFUSE_BITS = 32 and EFUSE_PTR_W = 6;
  - the driver window constants READ_WIN = 32 and PROG_WIN = 256 cycles, for use by the bench.
- One natural sub-module: efuse_emu_chk, holding the PGM width counter and the violation detection. It is instantiated only under EFUSE_EMU_CHECK_EN.

Test Plan:
- INIT_VAL = 32'hA5A5_0F0F, driver read → dout = 32'hA5A5_0F0F, dout_valid pulses once, proto_err = 0.
- Driver program efuse_din = 32'h0000_8001, then read → fuse_word = 32'hA5A5_8F0F, burn_cnt = 1 (bit 0 was already 1), read returns 32'hA5A5_8F0F.
- Program 32'hFFFF_FFFF twice → burn_cnt saturates at the count of originally-zero bits (16); the second pass adds 0; fuse_word = 32'hFFFF_FFFF.
- PGM forced high for 6 cycles with PGM_MAX_CYC = 4 and EFUSE_EMU_CHECK_EN defined → proto_err = 1 and stays 1 through further legal reads. Same stimulus with the macro undefined → proto_err = 0.
- Deassert rst_n during a program at bit 10 → all outputs return to reset values and fuse_word = INIT_VAL; the next read returns INIT_VAL.
- 33 SCLK pulses in one CS-high read frame → bits 0..31 match fuse_word, DOUT = 0 on pulse 33, proto_err = 1.
